// File: rtl/soc_ahb4_pkg.sv
// Shared AHB4-Lite encodings and the per-port address-phase holding register type
// used by the external-bus arbiter.
package soc_ahb4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned AHB_PLEN = 32;

    typedef struct packed {
        logic [AHB_PLEN-1:0] addr;
        logic                write;
        logic [2:0]          size;
        logic [3:0]          prot;
        logic                lock;
    } hold_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } bus_state_e;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/soc_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, modulo NODES.
// Produces a one-hot grant, the winning index and a valid flag.
module soc_rr_arbiter #(
    parameter int NODES = 8,
    parameter int IDXW  = $clog2(NODES)
) (
    input  logic [NODES-1:0] req_i,
    input  logic [IDXW-1:0]  ptr_i,
    output logic [NODES-1:0] gnt_o,
    output logic [IDXW-1:0]  idx_o,
    output logic             vld_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        // Walk from the farthest offset down so the nearest requester wins last.
        for (int k = NODES - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NODES;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IDXW'(j);
                vld_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_ahb4_ext_arbiter.sv
// Merges NODES AHB4-Lite master ports onto one shared master port: one holding
// register per node, round-robin grants with lock stickiness, pipelined SINGLE transfers.
module soc_ahb4_ext_arbiter
    import soc_ahb4_pkg::*;
#(
    parameter int NODES = 8,
    parameter int PLEN  = 32,
    parameter int XLEN  = 32
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [NODES-1:0]            s_hsel,
    input  logic [NODES-1:0][PLEN-1:0]  s_haddr,
    input  logic [NODES-1:0][XLEN-1:0]  s_hwdata,
    input  logic [NODES-1:0]            s_hwrite,
    input  logic [NODES-1:0][2:0]       s_hsize,
    input  logic [NODES-1:0][2:0]       s_hburst,
    input  logic [NODES-1:0][3:0]       s_hprot,
    input  logic [NODES-1:0][1:0]       s_htrans,
    input  logic [NODES-1:0]            s_hmastlock,
    output logic [NODES-1:0][XLEN-1:0]  s_hrdata,
    output logic [NODES-1:0]            s_hready,
    output logic [NODES-1:0]            s_hresp,

    output logic                        m_hsel,
    output logic [PLEN-1:0]             m_haddr,
    output logic [XLEN-1:0]             m_hwdata,
    output logic                        m_hwrite,
    output logic [2:0]                  m_hsize,
    output logic [2:0]                  m_hburst,
    output logic [3:0]                  m_hprot,
    output logic [1:0]                  m_htrans,
    output logic                        m_hmastlock,
    input  logic [XLEN-1:0]             m_hrdata,
    input  logic                        m_hready,
    input  logic                        m_hresp
);

    localparam int IDXW = $clog2(NODES);

    hold_t            hold_q [NODES];
    hold_t            last_q;
    logic [NODES-1:0] pending_q;
    logic [IDXW-1:0]  owner_q;
    logic [IDXW-1:0]  rr_ptr_q;
    logic             lock_q;
    bus_state_e       state_q;

    logic             data_vld;
    logic             bus_free;
    logic [NODES-1:0] cap;
    logic [NODES-1:0] req;
    logic [NODES-1:0] lock_mask;
    logic [NODES-1:0] win_gnt;
    logic [IDXW-1:0]  win_idx;
    logic             win_vld;
    logic             grant;
    logic             accept;
    logic             lock_rel;
    hold_t            sel_hold;
    logic             unused_bits;

    assign data_vld = (state_q == ST_DATA);
    assign bus_free = !data_vld || m_hready;

    // Node-side responses: the data-phase owner sees the slave directly, everyone
    // else is stalled only while its captured request waits for the bus.
    always_comb begin
        s_hready = ~pending_q;
        s_hresp  = '0;
        s_hrdata = '0;
        if (data_vld) begin
            s_hready[owner_q] = m_hready;
            s_hresp[owner_q]  = m_hresp;
            s_hrdata[owner_q] = m_hrdata;
        end
    end

    always_comb begin
        cap         = '0;
        unused_bits = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            cap[i]      = s_hready[i] && s_hsel[i] && htrans_active(s_htrans[i]);
            unused_bits = unused_bits ^ (^s_hburst[i]) ^ s_htrans[i][0];
        end
    end

    // While a locked sequence is open only the lock holder may be granted.
    assign lock_mask = NODES'(1) << rr_ptr_q;
    assign req       = lock_q ? (pending_q & lock_mask) : pending_q;
    assign lock_rel  = lock_q && s_hready[rr_ptr_q] && !cap[rr_ptr_q];

    soc_rr_arbiter #(
        .NODES (NODES),
        .IDXW  (IDXW)
    ) u_rr (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );

    assign grant  = win_vld && bus_free;
    assign accept = grant && m_hready;

    assign sel_hold    = grant ? hold_q[win_idx] : last_q;
    assign m_hsel      = grant;
    assign m_htrans    = grant ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign m_hburst    = HBURST_SINGLE;
    assign m_haddr     = PLEN'(sel_hold.addr);
    assign m_hwrite    = sel_hold.write;
    assign m_hsize     = sel_hold.size;
    assign m_hprot     = sel_hold.prot;
    assign m_hmastlock = grant ? hold_q[win_idx].lock : lock_q;
    assign m_hwdata    = data_vld ? s_hwdata[owner_q] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NODES; i++) begin
                hold_q[i] <= '0;
            end
            last_q    <= '0;
            pending_q <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            for (int i = 0; i < NODES; i++) begin
                if (cap[i]) begin
                    hold_q[i] <= '{addr:  AHB_PLEN'(s_haddr[i]),
                                   write: s_hwrite[i],
                                   size:  s_hsize[i],
                                   prot:  s_hprot[i],
                                   lock:  s_hmastlock[i]};
                end
            end

            // A port cannot capture while pending, so clear and set never collide.
            pending_q <= (pending_q & ~(accept ? win_gnt : '0)) | cap;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_DATA;
                        owner_q <= win_idx;
                    end
                end
                ST_DATA: begin
                    if (m_hready) begin
                        if (accept) begin
                            owner_q <= win_idx;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                last_q <= hold_q[win_idx];
                lock_q <= hold_q[win_idx].lock;
                if (hold_q[win_idx].lock) begin
                    rr_ptr_q <= win_idx;
                end else if (win_idx == IDXW'(NODES - 1)) begin
                    rr_ptr_q <= '0;
                end else begin
                    rr_ptr_q <= win_idx + IDXW'(1);
                end
            end else if (lock_rel) begin
                lock_q <= 1'b0;
            end
        end
    end

endmodule
